multicycle_control: RTL and testbench

Sequencing FSM for the multicycle MIPS datapath, which shares one memory for instructions and data. It steps each instruction through fetch, decode, execute, memory and write-back, and drives every mux select and write enable of the datapath. It stalls on a memory ready handshake and halts on an unsupported opcode. It replaces the combinational decoder used by the single-cycle core.

---
 rtl/mips_mc_pkg.sv | 59 +++++
 rtl/multicycle_control_decode.sv | 83 ++++++++
 rtl/multicycle_control.sv | 132 +++++++++++++
 tb/tb_multicycle_control.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS controller: state and opcode
// encodings, mux-select encodings and the packed control word.
package mips_mc_pkg;

    localparam int OPC_W = 6;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_HALT   = 4'd15
    } state_t;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational map from the current state (and mem_ready in FETCH) to the
// datapath control word. Anything not set for a state stays 0.
module multicycle_control_decode
    import mips_mc_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.i_or_d    = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // IR load and PC+4 commit only on the cycle memory delivers
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencer: state register, next-state logic, sticky halt
// flag, and reset gating of all write enables.
module multicycle_control
    import mips_mc_pkg::*;
#(
    parameter int OPC_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic             reg_write,
    output logic             reg_dst,
    output logic [1:0]       pc_source,
    output logic [1:0]       alu_op,
    output logic [1:0]       alu_src_b,
    output logic             pc_en,
    output logic             halted,
    output logic [3:0]       state
);

    localparam int N_WEN = 5;

    state_t state_reg;
    state_t state_next;
    logic   halted_reg;
    ctrl_t  ctrl;

    logic [N_WEN-1:0] wen_raw;
    logic [N_WEN-1:0] wen_gated;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= S_FETCH;
            halted_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_next == S_HALT) begin
                halted_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == OP_RTYPE) begin
                    state_next = S_EXEC;
                end else if (opcode == OP_LW || opcode == OP_SW) begin
                    state_next = S_MEMADR;
                end else if (opcode == OP_BEQ) begin
                    state_next = S_BRANCH;
                end else if (opcode == OP_J) begin
                    state_next = S_JUMP;
                end else if (opcode == OP_ADDI) begin
                    state_next = S_ADDIEX;
                end else begin
                    state_next = S_HALT;
                end
            end
            S_MEMADR: begin
                // opcode is re-read here to pick the access direction
                if (opcode == OP_LW) begin
                    state_next = S_MEMRD;
                end else if (opcode == OP_SW) begin
                    state_next = S_MEMWR;
                end else begin
                    state_next = S_HALT;
                end
            end
            S_MEMRD:  state_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR:  state_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_next = S_ALUWB;
            S_ALUWB:  state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_JUMP:   state_next = S_FETCH;
            S_ADDIEX: state_next = S_ADDIWB;
            S_ADDIWB: state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_FETCH;
        endcase
    end

    multicycle_control_decode u_decode (
        .state     (state_reg),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    // Every architectural write enable is blocked while reset is held, so an
    // aborted instruction cannot commit anything after the reset edge.
    assign wen_raw = {ctrl.pc_write, ctrl.pc_write_cond, ctrl.ir_write,
                      ctrl.mem_write, ctrl.reg_write};

    generate
        for (genvar gi = 0; gi < N_WEN; gi++) begin : g_wen
            assign wen_gated[gi] = wen_raw[gi] & ~reset;
        end
    endgenerate

    assign pc_write      = wen_gated[4];
    assign pc_write_cond = wen_gated[3];
    assign ir_write      = wen_gated[2];
    assign mem_write     = wen_gated[1];
    assign reg_write     = wen_gated[0];
    assign pc_en         = wen_gated[4] | (wen_gated[3] & zero);

    assign i_or_d     = ctrl.i_or_d;
    assign mem_read   = ctrl.mem_read;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign alu_src_a  = ctrl.alu_src_a;
    assign reg_dst    = ctrl.reg_dst;
    assign pc_source  = ctrl.pc_source;
    assign alu_op     = ctrl.alu_op;
    assign alu_src_b  = ctrl.alu_src_b;

    assign halted = halted_reg;
    assign state  = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed per-cycle stimulus pushes
// the expected state and control word; a negedge monitor pops and compares.
module tb_multicycle_control;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_J     = 6'b000010;
    localparam logic [5:0] T_ADDI  = 6'b001000;
    localparam logic [5:0] T_ILL   = 6'b111111;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, alu_src_a, reg_write, reg_dst, pc_en, halted;
    logic [1:0] pc_source, alu_op, alu_src_b;
    logic [3:0] state;

    typedef struct {
        int          idx;
        logic [3:0]  st;
        logic [17:0] ctrl;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_n = 0;
    bit   stim_done = 0;

    multicycle_control #(.OPC_W(6)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .pc_source     (pc_source),
        .alu_op        (alu_op),
        .alu_src_b     (alu_src_b),
        .pc_en         (pc_en),
        .halted        (halted),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control table written from the per-state control list.
    function automatic logic [17:0] ref_ctrl(input logic [3:0] s, input logic rdy,
                                             input logic z, input logic rst);
        logic pw, pwc, iod, mr, mw, irw, m2r, asa, rw, rd, pcen, hlt;
        logic [1:0] pcs, aop, asb;
        {pw, pwc, iod, mr, mw, irw, m2r, asa, rw, rd, pcen, hlt} = '0;
        pcs = 2'b00; aop = 2'b00; asb = 2'b00;
        case (s)
            4'd0:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
            4'd1:  asb = 2'b11;
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  begin mr = 1; iod = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mw = 1; iod = 1; end
            4'd6:  begin asa = 1; aop = 2'b10; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; end
            4'd9:  begin pw = 1; pcs = 2'b10; end
            4'd10: begin asa = 1; asb = 2'b10; end
            4'd11: rw = 1;
            4'd15: hlt = 1;
            default: ;
        endcase
        if (rst) begin
            pw = 0; pwc = 0; irw = 0; mw = 0; rw = 0;
        end
        pcen = pw | (pwc & z);
        return {pw, pwc, iod, mr, mw, irw, m2r, asa, rw, rd, pcs, aop, asb, pcen, hlt};
    endfunction

    task automatic step(input logic r, input logic [5:0] opc, input logic rdy,
                        input logic z, input logic [3:0] es);
        exp_t e;
        reset = r; opcode = opc; mem_ready = rdy; zero = z;
        e.idx = step_n; e.st = es; e.ctrl = ref_ctrl(es, rdy, z, r);
        q.push_back(e);
        step_n++;
        @(posedge clk); #1;
    endtask

    // Monitor: one transaction per cycle, compared at the falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [17:0] act;
            e = q.pop_front();
            act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, alu_src_a, reg_write, reg_dst, pc_source, alu_op,
                   alu_src_b, pc_en, halted};
            checks += 2;
            if (state !== e.st) begin
                errors++;
                $display("FAIL state step=%0d actual=%0d expected=%0d", e.idx, state, e.st);
            end
            if (act !== e.ctrl) begin
                errors++;
                $display("FAIL ctrl step=%0d state=%0d actual=%b expected=%b",
                         e.idx, state, act, e.ctrl);
            end
            if (state === e.st && act === e.ctrl)
                $display("step=%0d state=%0d rst=%b opc=%b rdy=%b z=%b ctrl=%b ok",
                         e.idx, state, reset, opcode, mem_ready, zero, act);
        end
    end

    initial begin
        reset = 1; opcode = '0; zero = 0; mem_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        step(1, T_RTYPE, 1, 0, 4'd0);      // reset held: FETCH enables forced off

        // R-type; opcode changes in EXEC/ALUWB and mem_ready=0 in DECODE are ignored
        step(0, T_RTYPE, 1, 0, 4'd0);
        step(0, T_RTYPE, 0, 0, 4'd1);
        step(0, T_ILL,   0, 0, 4'd6);
        step(0, T_ILL,   1, 0, 4'd7);

        // Reset held two cycles from EXEC
        step(0, T_RTYPE, 1, 0, 4'd0);
        step(0, T_RTYPE, 1, 0, 4'd1);
        step(1, T_RTYPE, 1, 0, 4'd6);
        step(1, T_RTYPE, 1, 0, 4'd0);
        step(0, T_RTYPE, 1, 0, 4'd0);      // released: normal FETCH
        step(0, T_RTYPE, 1, 0, 4'd1);
        step(0, T_RTYPE, 1, 0, 4'd6);
        step(1, T_RTYPE, 1, 0, 4'd7);      // reset in ALUWB suppresses reg_write
        step(1, T_RTYPE, 1, 0, 4'd0);

        // lw with two stall cycles in MEMRD
        step(0, T_LW, 1, 0, 4'd0);
        step(0, T_LW, 1, 0, 4'd1);
        step(0, T_LW, 1, 0, 4'd2);
        step(0, T_LW, 0, 0, 4'd3);
        step(0, T_LW, 0, 0, 4'd3);
        step(0, T_LW, 1, 0, 4'd3);
        step(0, T_LW, 1, 0, 4'd4);

        // sw with one stall in MEMWR
        step(0, T_SW, 1, 0, 4'd0);
        step(0, T_SW, 1, 0, 4'd1);
        step(0, T_SW, 1, 0, 4'd2);
        step(0, T_SW, 0, 0, 4'd5);
        step(0, T_SW, 1, 0, 4'd5);

        // beq taken, then not taken
        step(0, T_BEQ, 1, 1, 4'd0);
        step(0, T_BEQ, 1, 1, 4'd1);
        step(0, T_BEQ, 1, 1, 4'd8);
        step(0, T_BEQ, 1, 0, 4'd0);
        step(0, T_BEQ, 1, 0, 4'd1);
        step(0, T_BEQ, 1, 0, 4'd8);

        // j after a three-cycle FETCH stall
        for (int i = 0; i < 3; i++) step(0, T_J, 0, 0, 4'd0);
        step(0, T_J, 1, 0, 4'd0);
        step(0, T_J, 1, 0, 4'd1);
        step(0, T_J, 1, 0, 4'd9);

        // addi
        step(0, T_ADDI, 1, 0, 4'd0);
        step(0, T_ADDI, 1, 0, 4'd1);
        step(0, T_ADDI, 1, 0, 4'd10);
        step(0, T_ADDI, 1, 0, 4'd11);

        // illegal opcode: HALT is sticky, only reset leaves it
        step(0, T_ILL, 1, 0, 4'd0);
        step(0, T_ILL, 1, 0, 4'd1);
        for (int i = 0; i < 11; i++) step(0, T_RTYPE, 1, 1, 4'd15);
        step(1, T_RTYPE, 1, 0, 4'd15);
        step(0, T_RTYPE, 1, 0, 4'd0);
        step(0, T_RTYPE, 1, 0, 4'd1);

        stim_done = 1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout stim_done=%0d expected=1", stim_done);
        $fatal(1, "timeout");
    end

endmodule
